// File: rtl/fetch_ctrl_pkg.sv
// Shared encodings for the fetch sequencing controller: next-PC source
// classes and controller state codes.
package fetch_ctrl_pkg;

    typedef enum logic [2:0] {
        PCNORMAL = 3'd0,
        PCBRANCH = 3'd1,
        PCJUMP   = 3'd2,
        PCJREG   = 3'd3,
        PCERET   = 3'd4
    } pcsrc_t;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        HOLD    = 2'd1,
        INT_ACK = 2'd2
    } fetch_state_t;

    localparam int PCSRC_W = 3;
    localparam int STATE_W = 2;

    // Branches and jumps always fetch their delay slot; eret does not.
    function automatic logic has_delay_slot(input logic [PCSRC_W-1:0] src);
        return (src == PCBRANCH) || (src == PCJUMP) || (src == PCJREG);
    endfunction

    function automatic logic is_redirect(input logic [PCSRC_W-1:0] src);
        return has_delay_slot(src) || (src == PCERET);
    endfunction

endpackage

// File: rtl/fetch_ctrl_stall_monitor.sv
// Frozen-cycle statistics: a saturating total stall counter and a sticky
// watchdog that trips when one continuous freeze lasts STALL_MAX cycles.
module fetch_ctrl_stall_monitor
    import fetch_ctrl_pkg::*;
#(
    parameter int               CNT_W     = 16,
    parameter logic [CNT_W-1:0] STALL_MAX = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             froze,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             stall_timeout
);

    logic [CNT_W-1:0] run_len;
    logic [CNT_W:0]   run_len_inc;
    logic             cnt_full;
    logic             run_full;

    assign run_len_inc = {1'b0, run_len} + {{CNT_W{1'b0}}, 1'b1};
    assign cnt_full    = &stall_cnt;
    assign run_full    = &run_len;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (froze && !cnt_full) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_len <= '0;
        end else if (!froze) begin
            run_len <= '0;
        end else if (!run_full) begin
            run_len <= run_len_inc[CNT_W-1:0];
        end
    end

    // Trip on the frozen cycle that brings the current run up to STALL_MAX.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_timeout <= 1'b0;
        end else if (froze && (run_len_inc >= {1'b0, STALL_MAX})) begin
            stall_timeout <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencing controller: merges interrupts, stalls and decode redirects
// into the fetch unit's freeze / PC-source controls and tracks the delay slot.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int               CNT_W     = 16,
    parameter logic [CNT_W-1:0] STALL_MAX = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               d_valid,
    input  logic [PCSRC_W-1:0] d_pcsrc,
    input  logic               cmp_taken,
    input  logic               hazard_stall,
    input  logic               d_is_mdu,
    input  logic               mdu_busy,
    input  logic               epc_wr_pending,
    input  logic               int_req,
    output logic               froze,
    output logic [PCSRC_W-1:0] pcsrc,
    output logic               alu_zero,
    output logic               request_int,
    output logic               flush_fd,
    output logic               bd_f,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic               stall_timeout,
    output logic [STATE_W-1:0] state
);

    fetch_state_t      state_q;
    fetch_state_t      state_d;
    logic              bd_d;
    logic              stall;
    logic              redir;
    pcsrc_t            rd_pcsrc;
    logic              rd_alu_zero;
    logic              rd_flush;
    logic              rd_bd;

    assign stall = hazard_stall
                 | (d_is_mdu & mdu_busy)
                 | (d_valid & (d_pcsrc == PCERET) & epc_wr_pending);

    assign redir = d_valid && is_redirect(d_pcsrc);

    // What an unstalled decode instruction asks of fetch this cycle.
    always_comb begin
        rd_pcsrc    = PCNORMAL;
        rd_alu_zero = 1'b0;
        rd_flush    = 1'b0;
        rd_bd       = 1'b0;
        if (redir) begin
            rd_pcsrc    = pcsrc_t'(d_pcsrc);
            rd_alu_zero = (d_pcsrc == PCBRANCH) && cmp_taken;
            rd_flush    = (d_pcsrc == PCERET);
            rd_bd       = has_delay_slot(d_pcsrc);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            bd_f    <= 1'b0;
        end else begin
            state_q <= state_d;
            bd_f    <= bd_d;
        end
    end

    always_comb begin
        froze       = 1'b0;
        pcsrc       = PCNORMAL;
        alu_zero    = 1'b0;
        request_int = 1'b0;
        flush_fd    = 1'b0;
        state_d     = state_q;
        bd_d        = 1'b0;
        case (state_q)
            RUN, HOLD: begin
                if (int_req) begin
                    request_int = 1'b1;
                    flush_fd    = 1'b1;
                    state_d     = INT_ACK;
                end else if (stall) begin
                    froze   = 1'b1;
                    state_d = HOLD;
                    bd_d    = bd_f;
                end else begin
                    pcsrc    = rd_pcsrc;
                    alu_zero = rd_alu_zero;
                    flush_fd = rd_flush;
                    bd_d     = rd_bd;
                    state_d  = RUN;
                end
            end
            // The level interrupt stays asserted until CP0 drops it; never re-request.
            INT_ACK: begin
                state_d = int_req ? INT_ACK : RUN;
                if (stall) begin
                    froze = 1'b1;
                    bd_d  = bd_f;
                end else begin
                    pcsrc    = rd_pcsrc;
                    alu_zero = rd_alu_zero;
                    flush_fd = rd_flush;
                    bd_d     = rd_bd;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
        if (reset) begin
            froze       = 1'b0;
            pcsrc       = PCNORMAL;
            alu_zero    = 1'b0;
            request_int = 1'b0;
            flush_fd    = 1'b0;
        end
    end

    assign state = state_q;

    fetch_ctrl_stall_monitor #(
        .CNT_W     (CNT_W),
        .STALL_MAX (STALL_MAX)
    ) u_stall_monitor (
        .clk           (clk),
        .reset         (reset),
        .froze         (froze),
        .stall_cnt     (stall_cnt),
        .stall_timeout (stall_timeout)
    );

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Sequencing controller for the fetch unit. Each cycle it decides the fetch unit's freeze, next-PC source, branch-taken and interrupt-request inputs. It merges decode-stage redirects, pipeline stalls, CP0 interrupts and eret, and tracks the branch delay slot. It sits between decode/hazard/CP0 logic and the fetch unit, and drives the fetch unit's Froze, PCSrc, ALUZero and requestInt inputs.

Parameters:
STALL_MAX, 16'd1024, consecutive frozen cycles before stall_timeout latches
CNT_W, 16, width of the saturating stall-cycle counter

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
d_valid  in  1  decode stage holds a real instruction
d_pcsrc  in  3  redirect class of the decode instruction (PCNORMAL/PCBRANCH/PCJUMP/PCJREG/PCERET)
cmp_taken  in  1  branch condition true (decode-stage compare)
hazard_stall  in  1  load-use or forwarding stall from the hazard unit
d_is_mdu  in  1  decode instruction uses the mult/div unit
mdu_busy  in  1  mult/div unit busy
epc_wr_pending  in  1  mtc0 to EPC in E or M stage
int_req  in  1  CP0 interrupt/exception request (level)
froze  out  1  to fetch Froze
pcsrc  out  3  to fetch PCSrc
alu_zero  out  1  to fetch ALUZero (branch taken)
request_int  out  1  to fetch requestInt
flush_fd  out  1  clear the F/D pipeline register
bd_f  out  1  instruction now in F is a delay slot (for CP0 BD)
stall_cnt  out  CNT_W  saturating count of frozen cycles
stall_timeout  out  1  sticky watchdog flag
state  out  2  FSM state, for debug

Behaviour:
- The clock and reset are named clk and reset. Reset is asynchronous and active-high.
- Reset values: state=RUN, bd_f=0, stall_cnt=0, stall_timeout=0, run-length counter=0. With reset high, combinational outputs are froze=0, pcsrc=PCNORMAL, alu_zero=0, request_int=0, flush_fd=0.
- stall = hazard_stall | (d_is_mdu & mdu_busy) | (d_valid & d_pcsrc==PCERET & epc_wr_pending).
- States: RUN(0), HOLD(1), INT_ACK(2). State 3 is illegal and returns to RUN.
- Priority within a cycle: interrupt > stall > redirect > normal.
- RUN/HOLD with int_req=1 (taken from RUN or HOLD, regardless of stall):
  - request_int=1, flush_fd=1, froze=0, pcsrc=PCNORMAL.
  - Next state INT_ACK; bd_f<=0.
- INT_ACK:
  - request_int=0, stall and redirects are handled as in RUN.
  - Stays in INT_ACK while int_req=1; a level interrupt is never re-requested.
  - Goes to RUN when int_req=0.
- Stall (no interrupt):
  - froze=1, pcsrc=PCNORMAL, alu_zero=0, flush_fd=0.
  - A pending decode redirect is deferred, not lost, because decode holds it.
  - State goes to HOLD; bd_f holds its value.
- Redirect with no stall, d_valid=1:
  - pcsrc=d_pcsrc; alu_zero=cmp_taken only when d_pcsrc==PCBRANCH, else 0.
  - For PCBRANCH, PCJUMP and PCJREG, bd_f<=1, taken or not, because the slot is always fetched.
  - PCERET has no delay slot: flush_fd=1 and bd_f<=0.
- Otherwise pcsrc=PCNORMAL and bd_f<=0 on any non-frozen cycle.
- HOLD returns to RUN on the first non-stall cycle. The redirect is issued in that same cycle, so there is zero extra latency.
- d_valid=0 forces pcsrc=PCNORMAL whatever d_pcsrc is.
- stall_cnt increments on each froze=1 cycle and saturates at all-ones.
- The run-length counter increments on consecutive froze=1 cycles and clears on froze=0.
  - stall_timeout sets when the run length reaches STALL_MAX and clears only on reset.
- Reset mid-stall or in INT_ACK goes immediately to reset values; no redirect survives.

Decomposition:
- PCNORMAL/PCBRANCH/PCJUMP/PCJREG/PCERET encodings (0/1/2/3/4) and the RUN/HOLD/INT_ACK state codes live in the shared paras.v.
- The stall-cycle and run-length counters with saturation and watchdog form one natural sub-module: stall_monitor.

Test Plan:
- Reset check: reset pulse mid-clock -> outputs clear asynchronously; state=0, stall_cnt=0.
- Branch taken: d_valid=1, d_pcsrc=PCBRANCH, cmp_taken=1, no stall -> pcsrc=1, alu_zero=1, bd_f=1 next cycle.
- Branch not taken: same as above with cmp_taken=0 -> pcsrc=1, alu_zero=0, bd_f=1 next cycle.
- MDU stall on jr: d_is_mdu=1, mdu_busy=1 for 3 cycles with d_pcsrc=PCJREG -> froze=1 for 3 cycles, state=HOLD, pcsrc=0 during the stall, then pcsrc=3 on cycle 4 with state=RUN; stall_cnt=3.
- Eret hazard: eret with epc_wr_pending=1 for 2 cycles -> froze=1 for 2 cycles, then pcsrc=4, flush_fd=1, bd_f=0.
- Interrupt during stall: int_req=1 while hazard_stall=1 -> request_int=1 for exactly one cycle, flush_fd=1, froze=0. Holding int_req=1 for 5 cycles -> request_int stays 0 and state=INT_ACK. int_req=0 -> state=RUN.
- Watchdog: STALL_MAX=4 with hazard_stall held for 6 cycles -> stall_timeout rises on the 4th frozen cycle and stays high after the stall ends.
